ahb_burst_arbiter: RTL and testbench
====================================

AHB_BURST_ARBITER -- requirements
Module: ahb_burst_arbiter

Interface
REQ-001: Clock and reset SHALL be HCLK and HRESET; one clock; HRESET is synchronous and active-high.
REQ-002: Parameters SHALL be: ADDRWIDTH, default 32, HADDR width; DATAWIDTH, default 32, HWDATA/HRDATA width.
REQ-003: Ports SHALL be, in order:
- HCLK in 1 clock
- HRESET in 1 sync reset
- REQ0/REQ1 in 1 each, burst request
- ADDR0/ADDR1 in 8 each, start byte address
- WRITE0/WRITE1 in 1 each, 1 = write
- LEN0/LEN1 in 2 each: 00 SINGLE, 01 INCR4, 10 INCR8, 11 INCR16
- WDATA0/WDATA1 in 8 each, write byte
- GNT0/GNT1 out 1 each, grant pulse
- WREADY0/WREADY1 out 1 each, write byte consumed
- RVALID0/RVALID1 out 1 each, read byte valid
- RDATA out 8, read byte
- DONE0/DONE1 out 1 each, burst finished
- ERR out 1, qualifies DONE
- HADDR out ADDRWIDTH
- HTRANS out 2 (Trans_t)
- HBURST out 3 (BType_t)
- HSIZE out 3
- HWRITE out 1
- HWDATA out DATAWIDTH
- HREADY in 1
- HRESP in 1 (Response_t)
- HRDATA in DATAWIDTH

Function
REQ-004: FSM SHALL have states IDLE, ADDR (address phases in flight), LAST (final data phase only), ERRW (error second cycle).
REQ-005: In IDLE with any REQ high at a clock edge, the FSM SHALL go to ADDR, latch the granted requester's ADDR/WRITE/LEN, and pulse that GNT for exactly the first ADDR cycle.
REQ-006: Arbitration SHALL be round-robin. A priority pointer resets to requester 0. On simultaneous requests the pointed requester wins. The pointer flips to the other requester after every grant.
REQ-007: In ADDR, the first beat SHALL drive HTRANS=NONSEQ and later beats HTRANS=SEQ. HBURST SHALL match the latched LEN (SINGLE/INCR4/INCR8/INCR16), HSIZE=000, HWRITE=latched WRITE, HADDR={zeros, beat address}.
REQ-008: The beat address SHALL start at latched ADDR and increment by 1 per accepted address phase, computed in 8 bits (0xFF+1 wraps to 0x00).
REQ-009: Beat count SHALL be 1/4/8/16 per LEN. A 4-bit counter SHALL advance only on HREADY=1.
REQ-010: With HREADY=0, HADDR, HTRANS, HBURST, HWRITE and HWDATA SHALL hold, and no counter or address SHALL advance.
REQ-011: When the last address phase is accepted, the FSM SHALL enter LAST with HTRANS=IDLE. In LAST with HREADY=1 it SHALL return to IDLE and pulse DONE of the owner one cycle later with ERR=0.
REQ-012: Write data SHALL lag address by one cycle. During each data phase, HWDATA={zeros, owner WDATA}. WREADY of the owner SHALL be high in each data-phase cycle with HREADY=1.
REQ-013: Reads SHALL set RDATA=HRDATA[7:0] and pulse the owner's RVALID in each data-phase cycle with HREADY=1, combinationally with that cycle.
REQ-014: When HRESP=ERROR and HREADY=0 are sampled, the FSM SHALL go to ERRW and drive HTRANS=IDLE. On HREADY=1 in ERRW it SHALL go to IDLE and pulse DONE with ERR=1. Remaining beats SHALL be abandoned, and no WREADY/RVALID SHALL be asserted for the errored beat.
REQ-015: At least one IDLE cycle SHALL separate consecutive bursts. REQ changes outside IDLE SHALL be ignored.
REQ-016: Outputs SHALL be GNT/WREADY/RVALID/DONE/ERR zero-or-pulse only. Non-owner strobes SHALL always be 0.

Reset
REQ-017: HRESET high at a clock edge SHALL force, at any time including mid-burst: IDLE, pointer=0, counter=0, HTRANS=IDLE, HADDR=0, HBURST=SINGLE, HSIZE=0, HWRITE=0, HWDATA=0, all strobes and ERR=0, RDATA=0. No DONE SHALL be issued for an interrupted burst.

Verification
REQ-018: REQ0=1, ADDR0=0x10, WRITE0=1, LEN0=01, HREADY=1 -> GNT0 one cycle; HTRANS NONSEQ, SEQ, SEQ, SEQ at HADDR 0x10-0x13, HBURST=INCR4; 4 WREADY0 pulses; DONE0=1, ERR=0.
REQ-019: REQ0=REQ1=1 from reset, both LEN=00 -> requester 0 granted first, then requester 1 after one IDLE cycle; pointer alternates on repeat.
REQ-020: Read INCR8 at ADDR1=0xFC with HREADY low 2 cycles on beat 3 -> HADDR sequence 0xFC-0xFF, 0x00-0x03 (wrap); outputs held during the stall; exactly 8 RVALID1 pulses.
REQ-021: HRESP=ERROR on beat 2 of INCR16 write (cycle 1 HREADY=0, cycle 2 HREADY=1) -> HTRANS=IDLE in the second error cycle; DONE0 with ERR=1; no further beats.
REQ-022: HRESET asserted mid-INCR16 -> next cycle all outputs at reset values; no DONE; next REQ1 granted normally.

Source files
------------

// File: rtl/ahb_burst_arbiter.sv
// ahb_burst_arbiter: round-robin front end for two byte-wide requesters sharing one
// AHB-Lite master port, issuing SINGLE/INCR4/INCR8/INCR16 bursts of byte transfers.
module ahb_burst_arbiter #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic [7:0]           ADDR0,
  input  logic [7:0]           ADDR1,
  input  logic                 WRITE0,
  input  logic                 WRITE1,
  input  logic [1:0]           LEN0,
  input  logic [1:0]           LEN1,
  input  logic [7:0]           WDATA0,
  input  logic [7:0]           WDATA1,
  output logic                 GNT0,
  output logic                 GNT1,
  output logic                 WREADY0,
  output logic                 WREADY1,
  output logic                 RVALID0,
  output logic                 RVALID1,
  output logic [7:0]           RDATA,
  output logic                 DONE0,
  output logic                 DONE1,
  output logic                 ERR,
  output logic [ADDRWIDTH-1:0] HADDR,
  output logic [1:0]           HTRANS,
  output logic [2:0]           HBURST,
  output logic [2:0]           HSIZE,
  output logic                 HWRITE,
  output logic [DATAWIDTH-1:0] HWDATA,
  input  logic                 HREADY,
  input  logic                 HRESP,
  input  logic [DATAWIDTH-1:0] HRDATA
);

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } trans_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR4  = 3'b011,
    BURST_INCR8  = 3'b101,
    BURST_INCR16 = 3'b111
  } btype_t;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } response_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_LAST = 2'b10,
    S_ERRW = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       ptr_q, ptr_d;
  logic       write_q, write_d;
  logic [1:0] len_q, len_d;
  logic [7:0] addr_q, addr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic       err_q, err_d;
  trans_t     htrans_q, htrans_d;
  btype_t     hburst_q, hburst_d;
  logic       hwrite_q, hwrite_d;

  logic       grant_sel;
  logic       dphase;
  logic       beat_ok;
  logic       err_resp;
  logic [7:0] owner_wdata;
  logic       unused_hrdata_hi;

  function automatic btype_t burst_of(input logic [1:0] len);
    case (len)
      2'b00:   burst_of = BURST_SINGLE;
      2'b01:   burst_of = BURST_INCR4;
      2'b10:   burst_of = BURST_INCR8;
      default: burst_of = BURST_INCR16;
    endcase
  endfunction

  function automatic logic [3:0] last_beat(input logic [1:0] len);
    case (len)
      2'b00:   last_beat = 4'd0;
      2'b01:   last_beat = 4'd3;
      2'b10:   last_beat = 4'd7;
      default: last_beat = 4'd15;
    endcase
  endfunction

  // A data phase is in flight once at least one address phase has been accepted.
  assign dphase    = ((state_q == S_ADDR) && (cnt_q != 4'd0)) || (state_q == S_LAST);
  assign beat_ok   = dphase & HREADY;
  assign err_resp  = dphase & (HRESP == RESP_ERROR) & ~HREADY;
  assign grant_sel = (REQ0 & REQ1) ? ptr_q : REQ1;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    write_d  = write_q;
    len_d    = len_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    err_d    = 1'b0;
    htrans_d = htrans_q;
    hburst_d = hburst_q;
    hwrite_d = hwrite_q;
    unique case (state_q)
      S_IDLE: begin
        if (REQ0 | REQ1) begin
          state_d  = S_ADDR;
          owner_d  = grant_sel;
          ptr_d    = ~grant_sel;
          write_d  = grant_sel ? WRITE1 : WRITE0;
          len_d    = grant_sel ? LEN1 : LEN0;
          addr_d   = grant_sel ? ADDR1 : ADDR0;
          cnt_d    = 4'd0;
          gnt_d    = grant_sel ? 2'b10 : 2'b01;
          htrans_d = TRANS_NONSEQ;
          hburst_d = burst_of(grant_sel ? LEN1 : LEN0);
          hwrite_d = grant_sel ? WRITE1 : WRITE0;
        end
      end
      S_ADDR: begin
        if (err_resp) begin
          state_d  = S_ERRW;
          htrans_d = TRANS_IDLE;
        end else if (HREADY) begin
          if (cnt_q == last_beat(len_q)) begin
            state_d  = S_LAST;
            htrans_d = TRANS_IDLE;
          end else begin
            cnt_d    = cnt_q + 4'd1;
            addr_d   = addr_q + 8'd1;
            htrans_d = TRANS_SEQ;
          end
        end
      end
      S_LAST: begin
        if (err_resp) begin
          state_d  = S_ERRW;
          htrans_d = TRANS_IDLE;
        end else if (HREADY) begin
          state_d  = S_IDLE;
          done_d   = owner_q ? 2'b10 : 2'b01;
          addr_d   = 8'h00;
          cnt_d    = 4'd0;
          hburst_d = BURST_SINGLE;
          hwrite_d = 1'b0;
        end
      end
      S_ERRW: begin
        // Second error cycle: remaining beats are dropped and DONE reports the error.
        if (HREADY) begin
          state_d  = S_IDLE;
          done_d   = owner_q ? 2'b10 : 2'b01;
          err_d    = 1'b1;
          addr_d   = 8'h00;
          cnt_d    = 4'd0;
          hburst_d = BURST_SINGLE;
          hwrite_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      write_q  <= 1'b0;
      len_q    <= 2'b00;
      addr_q   <= 8'h00;
      cnt_q    <= 4'd0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 1'b0;
      htrans_q <= TRANS_IDLE;
      hburst_q <= BURST_SINGLE;
      hwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      write_q  <= write_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      htrans_q <= htrans_d;
      hburst_q <= hburst_d;
      hwrite_q <= hwrite_d;
    end
  end

  // Requester handshake: the owner's WDATA is consumed, and RDATA is valid, in exactly
  // those cycles where its WREADY/RVALID is high; a writer holds WDATA until WREADY.
  assign owner_wdata = owner_q ? WDATA1 : WDATA0;
  assign HWDATA  = (dphase && write_q) ? {{(DATAWIDTH-8){1'b0}}, owner_wdata} : '0;
  assign WREADY0 = beat_ok & write_q & ~owner_q;
  assign WREADY1 = beat_ok & write_q & owner_q;
  assign RVALID0 = beat_ok & ~write_q & ~owner_q;
  assign RVALID1 = beat_ok & ~write_q & owner_q;
  assign RDATA   = (beat_ok && !write_q) ? HRDATA[7:0] : 8'h00;

  assign GNT0   = gnt_q[0];
  assign GNT1   = gnt_q[1];
  assign DONE0  = done_q[0];
  assign DONE1  = done_q[1];
  assign ERR    = err_q;
  assign HADDR  = {{(ADDRWIDTH-8){1'b0}}, addr_q};
  assign HTRANS = htrans_q;
  assign HBURST = hburst_q;
  assign HSIZE  = 3'b000;
  assign HWRITE = hwrite_q;

  assign unused_hrdata_hi = ^HRDATA[DATAWIDTH-1:8];

endmodule

// File: tb/tb_ahb_burst_arbiter.sv
// Directed bench for ahb_burst_arbiter: a beat-counting bus model is compared against
// every output each cycle, and literal sequences pin the model on each scenario.
module tb_ahb_burst_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          REQ0, REQ1;
  logic [7:0]    ADDR0, ADDR1;
  logic          WRITE0, WRITE1;
  logic [1:0]    LEN0, LEN1;
  logic [7:0]    WDATA0, WDATA1;
  logic          GNT0, GNT1, WREADY0, WREADY1, RVALID0, RVALID1;
  logic [7:0]    RDATA;
  logic          DONE0, DONE1, ERR;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST, HSIZE;
  logic          HWRITE;
  logic [DW-1:0] HWDATA;
  logic          HREADY, HRESP;
  logic [DW-1:0] HRDATA;

  ahb_burst_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WRITE0(WRITE0), .WRITE1(WRITE1), .LEN0(LEN0), .LEN1(LEN1),
    .WDATA0(WDATA0), .WDATA1(WDATA1), .GNT0(GNT0), .GNT1(GNT1),
    .WREADY0(WREADY0), .WREADY1(WREADY1), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .RDATA(RDATA), .DONE0(DONE0), .DONE1(DONE1), .ERR(ERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // ---------------- behavioural bus model ----------------
  // A burst is tracked as "number of address phases accepted"; the data phase of
  // beat acc-1 is in flight whenever acc > 0.
  int   m_busy = 0, m_err2 = 0, m_first = 0, m_owner = 0, m_ptr = 0, m_write = 0;
  int   m_start = 0, m_len = 0, m_nbeats = 1, m_acc = 0;
  int   m_done0 = 0, m_done1 = 0, m_err = 0;
  int   w;

  function automatic int beats_of(input int len);
    return (len == 0) ? 1 : (2 << len);
  endfunction

  function automatic int burst_code(input int len);
    case (len)
      0: return 0;
      1: return 3;
      2: return 5;
      default: return 7;
    endcase
  endfunction

  initial forever begin
    @(posedge HCLK);
    if (HRESET) begin
      m_busy = 0; m_err2 = 0; m_first = 0; m_acc = 0; m_ptr = 0;
      m_done0 = 0; m_done1 = 0; m_err = 0;
    end else begin
      m_first = 0; m_done0 = 0; m_done1 = 0; m_err = 0;
      if (!m_busy) begin
        if (REQ0 || REQ1) begin
          w        = (REQ0 && REQ1) ? m_ptr : (REQ1 ? 1 : 0);
          m_owner  = w;
          m_ptr    = 1 - w;
          m_busy   = 1;
          m_first  = 1;
          m_acc    = 0;
          m_err2   = 0;
          m_start  = w ? int'(ADDR1) : int'(ADDR0);
          m_write  = w ? int'(WRITE1) : int'(WRITE0);
          m_len    = w ? int'(LEN1) : int'(LEN0);
          m_nbeats = beats_of(m_len);
        end
      end else if (m_err2) begin
        if (HREADY) begin
          m_busy = 0; m_err2 = 0; m_err = 1;
          if (m_owner) m_done1 = 1; else m_done0 = 1;
        end
      end else if (m_acc > 0 && HRESP && !HREADY) begin
        m_err2 = 1;
      end else if (HREADY) begin
        if (m_acc == m_nbeats) begin
          m_busy = 0;
          if (m_owner) m_done1 = 1; else m_done0 = 1;
        end else begin
          m_acc = m_acc + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare + monitor ----------------
  int         cyc_n = 0;
  int         n_wr0, n_wr1, n_rv0, n_rv1, n_done_ok0, n_done_ok1, n_done_err;
  logic [7:0] obs_addr_q[$];
  int         obs_gnt_q[$];
  int         obs_gcyc_q[$];
  logic [7:0] exp_q[$];

  int   e_dp, e_ok, e_htrans, e_haddr, e_hburst, e_hwrite, e_hwdata, e_rdata;

  initial forever begin
    @(negedge HCLK);
    if (chk_en) begin
      cyc_n++;
      e_dp = (m_busy && !m_err2 && m_acc > 0) ? 1 : 0;
      e_ok = (e_dp && HREADY) ? 1 : 0;
      if (!m_busy || m_err2 || m_acc == m_nbeats) e_htrans = 0;
      else e_htrans = (m_acc == 0) ? 2 : 3;
      e_haddr  = m_busy ? ((m_start + ((m_acc < m_nbeats) ? m_acc : m_nbeats - 1)) % 256) : 0;
      e_hburst = m_busy ? burst_code(m_len) : 0;
      e_hwrite = m_busy ? m_write : 0;
      e_hwdata = (e_dp && m_write) ? (m_owner ? int'(WDATA1) : int'(WDATA0)) : 0;
      e_rdata  = (e_ok && !m_write) ? int'(HRDATA[7:0]) : 0;
      check("htrans", HTRANS, e_htrans);
      check("haddr", HADDR, e_haddr);
      check("hburst", HBURST, e_hburst);
      check("hsize", HSIZE, 0);
      check("hwrite", HWRITE, e_hwrite);
      check("hwdata", HWDATA, e_hwdata);
      check("gnt0", GNT0, (m_first && m_owner == 0));
      check("gnt1", GNT1, (m_first && m_owner == 1));
      check("wready0", WREADY0, (e_ok && m_write && m_owner == 0));
      check("wready1", WREADY1, (e_ok && m_write && m_owner == 1));
      check("rvalid0", RVALID0, (e_ok && !m_write && m_owner == 0));
      check("rvalid1", RVALID1, (e_ok && !m_write && m_owner == 1));
      check("rdata", RDATA, e_rdata);
      check("done0", DONE0, m_done0);
      check("done1", DONE1, m_done1);
      check("err", ERR, m_err);
      if (HTRANS[1] && HREADY) obs_addr_q.push_back(HADDR[7:0]);
      if (GNT0) begin obs_gnt_q.push_back(0); obs_gcyc_q.push_back(cyc_n); end
      if (GNT1) begin obs_gnt_q.push_back(1); obs_gcyc_q.push_back(cyc_n); end
      if (WREADY0) n_wr0++;
      if (WREADY1) n_wr1++;
      if (RVALID0) n_rv0++;
      if (RVALID1) n_rv1++;
      if (DONE0 && !ERR) n_done_ok0++;
      if (DONE1 && !ERR) n_done_ok1++;
      if ((DONE0 || DONE1) && ERR) n_done_err++;
    end
  end

  // ---------------- drivers ----------------
  initial forever begin
    @(posedge HCLK);
    #1;
    WDATA0 = 8'($urandom_range(0, 255));
    WDATA1 = 8'($urandom_range(0, 255));
    HRDATA = $urandom;
  end

  task automatic clear_obs();
    obs_addr_q.delete();
    obs_gnt_q.delete();
    obs_gcyc_q.delete();
    n_wr0 = 0; n_wr1 = 0; n_rv0 = 0; n_rv1 = 0;
    n_done_ok0 = 0; n_done_ok1 = 0; n_done_err = 0;
  endtask

  task automatic check_addr_seq(input string name);
    check({name, "_count"}, obs_addr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_addr_q.size(); i++)
      check(name, obs_addr_q[i], exp_q[i]);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!(DONE0 || DONE1) && k < budget) begin
      step();
      k++;
    end
    check("done_timeout", (k < budget), 1);
    step();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
    REQ0 = 0; REQ1 = 0; ADDR0 = 0; ADDR1 = 0; WRITE0 = 0; WRITE1 = 0; LEN0 = 0; LEN1 = 0;
    WDATA0 = 0; WDATA1 = 0; HRDATA = '0;
    step();
    chk_en = 1'b1;
    step();
    HRESET = 1'b0;
    check("rst_htrans", HTRANS, 0);
    check("rst_haddr", HADDR, 0);
    check("rst_strobes", {GNT0, GNT1, WREADY0, WREADY1, RVALID0, RVALID1, DONE0, DONE1, ERR}, 0);

    // INCR4 write from requester 0 at 0x10, bus always ready
    clear_obs();
    REQ0 = 1; ADDR0 = 8'h10; WRITE0 = 1; LEN0 = 2'b01;
    step();
    REQ0 = 0;
    check("a_gnt0", GNT0, 1);
    check("a_htrans_first", HTRANS, 2'b10);
    check("a_hburst", HBURST, 3'b011);
    wait_done(40);
    exp_q = {8'h10, 8'h11, 8'h12, 8'h13};
    check_addr_seq("a_addr_seq");
    check("a_wready0_count", n_wr0, 4);
    check("a_done0_ok", n_done_ok0, 1);
    check("a_done_err", n_done_err, 0);

    // simultaneous SINGLE requests from reset: strict alternation 0,1,0,1
    HRESET = 1; step(); HRESET = 0;
    clear_obs();
    REQ0 = 1; REQ1 = 1; LEN0 = 0; LEN1 = 0;
    ADDR0 = 8'h20; ADDR1 = 8'h40; WRITE0 = 0; WRITE1 = 1;
    for (int k = 0; k < 60 && obs_gnt_q.size() < 4; k++) step();
    REQ0 = 0; REQ1 = 0;
    wait_done(20);
    exp_q = {8'd0, 8'd1, 8'd0, 8'd1};
    check("b_grant_count", obs_gnt_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_gnt_q.size(); i++) check("b_grant_order", obs_gnt_q[i], exp_q[i]);
    if (obs_gcyc_q.size() >= 2) check("b_grant_gap", obs_gcyc_q[1] - obs_gcyc_q[0], 3);
    check("b_done_total", n_done_ok0 + n_done_ok1, 4);

    // INCR8 read from requester 1 at 0xFC, two wait states on beat 3, address wraps
    clear_obs();
    REQ1 = 1; ADDR1 = 8'hFC; WRITE1 = 0; LEN1 = 2'b10;
    step();
    REQ1 = 0;
    check("c_gnt1", GNT1, 1);
    for (int c = 0; c < 14; c++) begin
      HREADY = (c == 3 || c == 4) ? 1'b0 : 1'b1;
      if (c == 4) begin
        check("c_stall_haddr", HADDR, 32'hFF);
        check("c_stall_htrans", HTRANS, 2'b11);
        check("c_stall_rvalid1", RVALID1, 0);
      end
      step();
    end
    HREADY = 1;
    exp_q = {8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
    check_addr_seq("c_addr_seq");
    check("c_rvalid1_count", n_rv1, 8);
    check("c_done1_ok", n_done_ok1, 1);

    // INCR16 write from requester 0, ERROR response on the second data phase
    clear_obs();
    REQ0 = 1; ADDR0 = 8'h80; WRITE0 = 1; LEN0 = 2'b11;
    step();
    REQ0 = 0;
    for (int c = 0; c < 7; c++) begin
      HREADY = (c == 2) ? 1'b0 : 1'b1;
      HRESP  = (c == 2 || c == 3) ? 1'b1 : 1'b0;
      if (c == 2) check("d_htrans_err1", HTRANS, 2'b11);
      if (c == 3) check("d_htrans_err2", HTRANS, 2'b00);
      if (c == 4) check("d_done0_err", {DONE0, ERR}, 2'b11);
      if (c == 5) check("d_htrans_after", HTRANS, 2'b00);
      step();
    end
    HREADY = 1; HRESP = 0;
    exp_q = {8'h80, 8'h81};
    check_addr_seq("d_addr_seq");
    check("d_wready0_count", n_wr0, 1);
    check("d_done_err_count", n_done_err, 1);
    check("d_done0_ok", n_done_ok0, 0);

    // reset in the middle of an INCR16, then a fresh request from requester 1
    clear_obs();
    REQ0 = 1; ADDR0 = 8'h30; WRITE0 = 1; LEN0 = 2'b11;
    step();
    REQ0 = 0;
    repeat (5) step();
    HRESET = 1;
    step();
    HRESET = 0;
    check("e_htrans", HTRANS, 0);
    check("e_haddr", HADDR, 0);
    check("e_hburst", HBURST, 0);
    check("e_hwrite_hwdata", {HWRITE, HWDATA}, 0);
    check("e_strobes", {GNT0, GNT1, WREADY0, WREADY1, RVALID0, RVALID1, DONE0, DONE1, ERR, RDATA}, 0);
    repeat (3) step();
    check("e_no_done", n_done_ok0 + n_done_ok1 + n_done_err, 0);
    REQ1 = 1; ADDR1 = 8'h55; WRITE1 = 0; LEN1 = 2'b00;
    step();
    REQ1 = 0;
    check("e_gnt1", GNT1, 1);
    check("e_haddr_new", HADDR, 32'h55);
    wait_done(20);
    check("e_done1_ok", n_done_ok1, 1);
    check("e_rvalid1_count", n_rv1, 1);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected scenario completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
